// File: rtl/stack_op_ctrl_if.sv
// ----------------------------------------------------------------------------
// stack_op_ctrl_if
// Bundles every non-clock signal of stack_op_ctrl:
//   op_valid/op_ready/op_type/op_data : operation request from the CPU control FSM
//   sp                                : current stack pointer from sp_mod
//   sp_sel/sp_data_bus/write_temp_buf : controls towards sp_mod
//   mem_addr/mem_wdata/mem_we/mem_re  : byte-wide memory request
//   mem_rdata/mem_ack                 : memory response
//   pop_data/done/err                 : operation result
// master : the surrounding system (CPU, sp_mod, memory)
// slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface stack_op_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_type;
    logic [15:0] op_data;
    logic [15:0] sp;
    logic [2:0]  sp_sel;
    logic [7:0]  sp_data_bus;
    logic        write_temp_buf;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [15:0] pop_data;
    logic        done;
    logic        err;

    modport master (
        output op_valid, op_type, op_data, sp, mem_rdata, mem_ack,
        input  op_ready, sp_sel, sp_data_bus, write_temp_buf,
               mem_addr, mem_wdata, mem_we, mem_re, pop_data, done, err
    );

    modport slave (
        input  op_valid, op_type, op_data, sp, mem_rdata, mem_ack,
        output op_ready, sp_sel, sp_data_bus, write_temp_buf,
               mem_addr, mem_wdata, mem_we, mem_re, pop_data, done, err
    );
endinterface

// File: rtl/stack_op_ctrl.sv
// ----------------------------------------------------------------------------
// stack_op_ctrl
// Sequencer for the stack-pointer datapath. Expands one stack operation
// (PUSH16, POP16, LD_SP_IMM16, ADD_SP_REL8) into per-cycle sp_mod controls
// and byte-wide memory accesses guarded by an ack timeout.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation silently
//   bus   : stack_op_ctrl_if.slave (request, sp_mod controls, memory, result)
// ----------------------------------------------------------------------------
module stack_op_ctrl #(
    parameter int unsigned ACK_TIMEOUT     = 15,
    parameter logic [2:0]  SP_SEL_SP       = 3'd0,
    parameter logic [2:0]  SP_SEL_INCR     = 3'd1,
    parameter logic [2:0]  SP_SEL_DECR     = 3'd2,
    parameter logic [2:0]  SP_SEL_DATA_BUS = 3'd3,
    parameter logic [2:0]  SP_SEL_REL      = 3'd4
) (
    input logic           clock,
    input logic           reset,
    stack_op_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        OP_PUSH16 = 2'd0,
        OP_POP16  = 2'd1,
        OP_LD_SP  = 2'd2,
        OP_REL    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_DEC1, S_WR_HI, S_DEC2, S_WR_LO,
        S_RD_LO, S_INC1, S_RD_HI, S_INC2,
        S_LD_LO, S_LD_HI, S_REL, S_DONE
    } state_e;

    state_e             state_q;
    logic [15:0]        op_data_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [7:0]         rd_lo_q;
    logic [7:0]         rd_hi_q;
    logic               op_ready_q;
    logic [2:0]         sp_sel_q;
    logic [7:0]         sp_data_bus_q;
    logic               write_temp_buf_q;
    logic [7:0]         mem_wdata_q;
    logic               mem_we_q;
    logic               mem_re_q;
    logic [15:0]        pop_data_q;
    logic               done_q;
    logic               err_q;

    // Access aborts once the full wait allowance is used up without an ack.
    logic wait_expired;
    assign wait_expired = (wait_cnt_q == CNT_W'(ACK_TIMEOUT));

    // NOTE: every register below uses non-blocking assignments so all state
    // updates of one edge see the pre-edge values, whatever their order here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            op_data_q        <= '0;
            wait_cnt_q       <= '0;
            rd_lo_q          <= '0;
            rd_hi_q          <= '0;
            op_ready_q       <= 1'b1;
            sp_sel_q         <= SP_SEL_SP;
            sp_data_bus_q    <= '0;
            write_temp_buf_q <= 1'b0;
            mem_wdata_q      <= '0;
            mem_we_q         <= 1'b0;
            mem_re_q         <= 1'b0;
            pop_data_q       <= '0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            // Outputs are registered for the state being entered: start from
            // the idle values and let each transition raise what it needs.
            op_ready_q       <= 1'b0;
            sp_sel_q         <= SP_SEL_SP;
            sp_data_bus_q    <= '0;
            write_temp_buf_q <= 1'b0;
            mem_wdata_q      <= '0;
            mem_we_q         <= 1'b0;
            mem_re_q         <= 1'b0;
            done_q           <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    op_ready_q <= 1'b1;
                    if (bus.op_valid) begin
                        op_ready_q <= 1'b0;
                        op_data_q  <= bus.op_data;
                        err_q      <= 1'b0;
                        unique case (op_e'(bus.op_type))
                            OP_PUSH16: begin
                                state_q  <= S_DEC1;
                                sp_sel_q <= SP_SEL_DECR;
                            end
                            OP_POP16: begin
                                state_q    <= S_RD_LO;
                                mem_re_q   <= 1'b1;
                                wait_cnt_q <= '0;
                            end
                            OP_LD_SP: begin
                                state_q          <= S_LD_LO;
                                sp_data_bus_q    <= bus.op_data[7:0];
                                write_temp_buf_q <= 1'b1;
                            end
                            OP_REL: begin
                                state_q       <= S_REL;
                                sp_data_bus_q <= bus.op_data[7:0];
                                sp_sel_q      <= SP_SEL_REL;
                            end
                        endcase
                    end
                end

                // ---------------- PUSH16 ----------------
                S_DEC1: begin
                    state_q     <= S_WR_HI;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= op_data_q[15:8];
                    wait_cnt_q  <= '0;
                end
                S_WR_HI: begin
                    if (bus.mem_ack) begin
                        state_q  <= S_DEC2;
                        sp_sel_q <= SP_SEL_DECR;
                    end else if (wait_expired) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= op_data_q[15:8];
                    end
                end
                S_DEC2: begin
                    state_q     <= S_WR_LO;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= op_data_q[7:0];
                    wait_cnt_q  <= '0;
                end
                S_WR_LO: begin
                    if (bus.mem_ack) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (wait_expired) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= op_data_q[7:0];
                    end
                end

                // ---------------- POP16 -----------------
                S_RD_LO: begin
                    if (bus.mem_ack) begin
                        rd_lo_q  <= bus.mem_rdata;
                        state_q  <= S_INC1;
                        sp_sel_q <= SP_SEL_INCR;
                    end else if (wait_expired) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        mem_re_q   <= 1'b1;
                    end
                end
                S_INC1: begin
                    state_q    <= S_RD_HI;
                    mem_re_q   <= 1'b1;
                    wait_cnt_q <= '0;
                end
                S_RD_HI: begin
                    if (bus.mem_ack) begin
                        rd_hi_q  <= bus.mem_rdata;
                        state_q  <= S_INC2;
                        sp_sel_q <= SP_SEL_INCR;
                    end else if (wait_expired) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        mem_re_q   <= 1'b1;
                    end
                end
                S_INC2: begin
                    // Only a POP that completed both reads reaches here, so
                    // pop_data never reflects a timed-out access.
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                    pop_data_q <= {rd_hi_q, rd_lo_q};
                end

                // ---------------- LD_SP_IMM16 -----------
                S_LD_LO: begin
                    // Low byte was parked in sp_mod's temp buffer last cycle;
                    // the high byte on data_bus now completes the load.
                    state_q       <= S_LD_HI;
                    sp_data_bus_q <= op_data_q[15:8];
                    sp_sel_q      <= SP_SEL_DATA_BUS;
                end
                S_LD_HI: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end

                // ---------------- ADD_SP_REL8 -----------
                S_REL: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end

                S_DONE: begin
                    state_q    <= S_IDLE;
                    op_ready_q <= 1'b1;
                end

                default: begin
                    state_q    <= S_IDLE;
                    op_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.op_ready       = op_ready_q;
    assign bus.sp_sel         = sp_sel_q;
    assign bus.sp_data_bus    = sp_data_bus_q;
    assign bus.write_temp_buf = write_temp_buf_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_re         = mem_re_q;
    assign bus.pop_data       = pop_data_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;

    // The address must follow sp live: sp_mod steps sp on the same edge that
    // enters an access state, so a registered copy would be one step stale.
    assign bus.mem_addr = (mem_we_q || mem_re_q) ? bus.sp : 16'h0000;

endmodule
